// File: rtl/caliptra_top_tb_pkg.sv
// Shared types for the SRAM error-injection wrapper: mode and FSM encodings,
// LFSR geometry and small mode-decoding helpers.
package caliptra_top_tb_pkg;

   typedef enum logic [2:0] {
      MODE_OFF        = 3'd0,
      MODE_SB_CONT    = 3'd1,
      MODE_DB_CONT    = 3'd2,
      MODE_SB_ONESHOT = 3'd3,
      MODE_DB_ONESHOT = 3'd4
   } inject_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_ACTIVE = 2'd2
   } inject_state_e;

   localparam int          LFSR_WIDTH = 16;
   // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;

   // Encodings 5-7 are reserved and behave like MODE_OFF
   function automatic logic mode_is_valid(input logic [2:0] m);
      return (m >= 3'd1) && (m <= 3'd4);
   endfunction

   function automatic logic mode_is_double(input inject_mode_e m);
      return (m == MODE_DB_CONT) || (m == MODE_DB_ONESHOT);
   endfunction

   function automatic logic mode_is_oneshot(input inject_mode_e m);
      return (m == MODE_SB_ONESHOT) || (m == MODE_DB_ONESHOT);
   endfunction

endpackage

// File: rtl/caliptra_sram.sv
// Single-port-style storage array with one write port and a registered read
// port; the read register resets and holds between reads, contents do not reset.
module caliptra_sram #(
   parameter int DATA_WIDTH = 39,
   parameter int DEPTH      = 16384,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/caliptra_sram_inject.sv
// SRAM wrapper that flips one or two bits of selected DUT writes to exercise
// ECC checkers; backdoor (ext_*) writes always land unmodified.
module caliptra_sram_inject
   import caliptra_top_tb_pkg::*;
#(
   parameter int          DATA_WIDTH = 39,
   parameter int          DEPTH      = 16384,
   parameter int          ADDR_WIDTH = $clog2(DEPTH),
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  cptra_rst_b,
   input  logic                  cs_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   input  logic [2:0]            inject_mode,
   input  logic                  inject_arm,
   input  logic [7:0]            inject_delay,
   output logic                  inject_busy,
   output logic [15:0]           inject_count,
   output logic                  collision,
   output inject_state_e         dbg_state_o
);

   localparam int                    PW     = $clog2(DATA_WIDTH);
   localparam logic [PW:0]           DW_EXT = DATA_WIDTH[PW:0];
   localparam logic [DATA_WIDTH-1:0] BIT0   = DATA_WIDTH'(1);

   inject_state_e         state_q, state_d;
   inject_mode_e          mode_q, mode_d;
   logic [7:0]            delay_q, delay_d;
   logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
   logic [15:0]           count_q, count_d;
   logic                  collision_q, collision_d;

   logic                  dut_wr, dut_rd, inj_wr;
   logic [PW:0]           pos_red;
   logic [PW-1:0]         pos_a, pos_b;
   logic [DATA_WIDTH-1:0] flip_mask, sram_wdata;
   logic                  sram_we;
   logic [ADDR_WIDTH-1:0] sram_waddr;

   // Access qualification: cs_i marks a DUT access in the cycle it is high and
   // we_i picks write vs read; ext_we owns the array that cycle and any
   // coincident DUT access is dropped (no write, no read, rdata_o holds).
   assign dut_wr = cs_i & we_i & ~ext_we;
   assign dut_rd = cs_i & ~we_i & ~ext_we;

   always_ff @(posedge clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A zero delay counter moves COUNT to ACTIVE on its own; the write in that
   // cycle (if any) is neither counted nor injected.
   always_comb begin
      state_d = state_q;
      if (inject_arm) begin
         state_d = mode_is_valid(inject_mode) ? ST_COUNT : ST_IDLE;
      end else begin
         case (state_q)
            ST_COUNT:  if (delay_q == 8'd0) state_d = ST_ACTIVE;
            ST_ACTIVE: if (dut_wr && mode_is_oneshot(mode_q)) state_d = ST_IDLE;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      inject_busy = (state_q != ST_IDLE);
      inj_wr      = (state_q == ST_ACTIVE) & dut_wr;
      dbg_state_o = state_q;
   end

   always_ff @(posedge clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         mode_q      <= MODE_OFF;
         delay_q     <= 8'd0;
         lfsr_q      <= LFSR_SEED;
         count_q     <= 16'd0;
         collision_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         delay_q     <= delay_d;
         lfsr_q      <= lfsr_d;
         count_q     <= count_d;
         collision_q <= collision_d;
      end
   end

   // Re-arming while busy restarts the delay but keeps count and LFSR history
   always_comb begin
      mode_d  = mode_q;
      delay_d = delay_q;
      if (inject_arm && mode_is_valid(inject_mode)) begin
         mode_d  = inject_mode_e'(inject_mode);
         delay_d = inject_delay;
      end else if ((state_q == ST_COUNT) && dut_wr && (delay_q != 8'd0)) begin
         delay_d = delay_q - 8'd1;
      end
   end

   always_comb begin
      lfsr_d      = inj_wr ? {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
      count_d     = (inj_wr && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
      collision_d = collision_q | (ext_we & cs_i);
   end

   // Low LFSR bits pick the flip position, folded once into [0, DATA_WIDTH)
   always_comb begin
      pos_red = {1'b0, lfsr_q[PW-1:0]};
      if (pos_red >= DW_EXT) begin
         pos_red = pos_red - DW_EXT;
      end
      pos_a     = pos_red[PW-1:0];
      pos_b     = ({1'b0, pos_a} == (DW_EXT - 1'b1)) ? '0 : pos_a + 1'b1;
      flip_mask = BIT0 << pos_a;
      if (mode_is_double(mode_q)) begin
         flip_mask = flip_mask | (BIT0 << pos_b);
      end
   end

   always_comb begin
      sram_we    = ext_we | dut_wr;
      sram_waddr = ext_we ? ext_addr : addr_i;
      if (ext_we) begin
         sram_wdata = ext_wdata;
      end else if (inj_wr) begin
         sram_wdata = wdata_i ^ flip_mask;
      end else begin
         sram_wdata = wdata_i;
      end
   end

   caliptra_sram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sram (
      .clk     (clk),
      .rst_b   (cptra_rst_b),
      .we_i    (sram_we),
      .waddr_i (sram_waddr),
      .wdata_i (sram_wdata),
      .re_i    (dut_rd),
      .raddr_i (addr_i),
      .rdata_o (rdata_o)
   );

   assign inject_count = count_q;
   assign collision    = collision_q;

endmodule

// File: doc/caliptra_sram_inject.md
CALIPTRA_SRAM_INJECT -- requirements
Module: caliptra_sram_inject

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 39: stored word width, including ECC bits.
REQ-002 SHALL have parameter DEPTH, default 16384: number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH): address width.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1: nonzero seed for bit-position selection.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk (input, 1) is the clock; cptra_rst_b (input, 1) is the reset.
REQ-006 cs_i  input  1  DUT access select.
REQ-007 we_i  input  1  DUT write enable.
REQ-008 addr_i  input  ADDR_WIDTH  DUT address.
REQ-009 wdata_i  input  DATA_WIDTH  DUT write data.
REQ-010 rdata_o  output  DATA_WIDTH  read data, registered.
REQ-011 ext_we  input  1  backdoor write strobe.
REQ-012 ext_addr  input  ADDR_WIDTH  backdoor address.
REQ-013 ext_wdata  input  DATA_WIDTH  backdoor write data.
REQ-014 inject_mode  input  3  injection mode, sampled on inject_arm.
REQ-015 inject_arm  input  1  one-cycle arm pulse.
REQ-016 inject_delay  input  8  number of DUT writes to skip before the first flip.
REQ-017 inject_busy  output  1  FSM is not in IDLE.
REQ-018 inject_count  output  16  injected writes, saturating at 16'hFFFF.
REQ-019 collision  output  1  sticky flag: a DUT access was dropped because of an ext write.

Function
REQ-020 Modes SHALL be:
- 0: off
- 1: single-bit, continuous
- 2: double-bit, continuous
- 3: single-bit, one-shot
- 4: double-bit, one-shot
- 5-7: treated as off
REQ-021 FSM states SHALL be IDLE, COUNT, ACTIVE.
REQ-022 In IDLE, inject_arm with a mode in 1-4 SHALL latch the mode and delay, then go to COUNT; inject_arm with a mode in 0 or 5-7 SHALL keep the FSM in IDLE.
REQ-023 In COUNT, each DUT write (cs_i & we_i & ~ext_we) SHALL decrement the delay counter. With the counter at 0, the FSM SHALL go to ACTIVE without consuming a write.
REQ-024 In ACTIVE, each DUT write SHALL be stored XOR a flip mask and SHALL increment inject_count. One-shot modes SHALL return to IDLE after that first injected write; continuous modes SHALL remain in ACTIVE.
REQ-025 Flip mask, with p = lfsr[$clog2(DATA_WIDTH)-1:0], reduced by DATA_WIDTH once if p >= DATA_WIDTH:
- single-bit: bit p only
- double-bit: bits p and (p+1) mod DATA_WIDTH
REQ-026 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance exactly once per injected write and hold otherwise.
REQ-027 inject_arm while busy SHALL re-latch the mode and delay and restart COUNT. inject_count and the LFSR SHALL be preserved.
REQ-028 inject_arm with mode 0 while busy SHALL abort to IDLE on the next cycle.
REQ-029 Reads: cs_i & ~we_i & ~ext_we SHALL return mem[addr_i] on rdata_o the next cycle. rdata_o SHALL hold its value when no read occurs.
REQ-030 Backdoor writes: ext_we SHALL write ext_wdata unmodified, never injected, and SHALL not count toward delay or inject_count.
REQ-031 Collision: ext_we with cs_i in the same cycle SHALL drop the DUT access, leave rdata_o unchanged, and set collision until reset.
REQ-032 Write/read to the same address on consecutive cycles SHALL return the newly written data, including any injected flip.
REQ-033 inject_count SHALL saturate at 16'hFFFF while injection continues.

Reset
REQ-034 cptra_rst_b low SHALL asynchronously force:
- FSM to IDLE
- inject_busy, inject_count, collision and rdata_o to 0
- delay counter and latched mode to 0
- LFSR to LFSR_SEED
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 Reset mid-ACTIVE SHALL abandon injection; the first post-reset write SHALL be stored unmodified.

Structure
REQ-037 caliptra_top_tb_pkg SHALL hold the inject_mode encoding enum, the FSM state enum, and the LFSR taps and width constants.
REQ-038 The storage array SHALL be an instance of caliptra_sram. The injection FSM, LFSR and mask generation SHALL be in this module; no other sub-module.

Verification
REQ-039 Mode 0, write 39'h1234 to addr 5, read addr 5 -> rdata_o = 39'h1234 one cycle later; inject_count = 0.
REQ-040 Arm mode 3 with delay 2, do 4 writes of 0 -> only the 3rd word has exactly one bit set; inject_count = 1; inject_busy falls after the 3rd write.
REQ-041 Arm mode 2 with delay 0, 3 writes of 0 -> each word has exactly two adjacent set bits (mod 39); positions differ per write and match a reference LFSR seeded 16'hACE1.
REQ-042 ext_we and a cs_i DUT write to the same address in the same cycle -> memory holds ext_wdata; collision = 1; delay counter unchanged.
REQ-043 Assert reset during ACTIVE mode 1 -> all outputs 0, then a write of 39'h7F stores and reads back 39'h7F.
REQ-044 Drive 65540 injected writes in mode 1 -> inject_count = 16'hFFFF.
